// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//   Matrix-keypad scanner. Drives one column at a time (one-hot), lets the
//   column settle for SCAN_DIV clocks, then samples the synchronised rows.
//   A single active row starts a debounce. A pattern that stays stable for
//   DEB_CYC clocks is accepted as a press. The scanner then stays on that
//   column until the release has been debounced as well. Each accepted
//   press produces exactly one key-code event on a valid/ready port.
//
// Ports
//   clk        in   1        system clock
//   reset      in   1        synchronous, active-high reset
//   row        in   NROWS    raw row inputs, active-high, asynchronous to clk
//   col        out  NCOLS    column drive, one-hot, active-high
//   key_code   out  CODE_W   col_idx*NROWS + row_idx of the accepted key
//   key_valid  out  1        key_code holds an unconsumed event
//   key_ready  in   1        consumer takes the event when key_valid && key_ready
//   key_held   out  1        high while the accepted key remains pressed
//   overrun    out  1        sticky: a press arrived while an event was pending
module keypad_scan_debounce #(
    parameter int NROWS    = 4,
    parameter int NCOLS    = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CYC  = 50000,
    parameter int CODE_W   = $clog2(NROWS * NCOLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NROWS-1:0]  row,
    output logic [NCOLS-1:0]  col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overrun
);

    localparam int CNT_MAX = (SCAN_DIV > DEB_CYC) ? SCAN_DIV : DEB_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CI_W    = (NCOLS > 1) ? $clog2(NCOLS) : 1;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Exactly one row active; zero or several rows (ghosting) is rejected.
    function automatic logic is_onehot(input logic [NROWS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NROWS; i++) begin
            n = n + 32'(v[i]);
        end
        return (n == 32'd1);
    endfunction

    // Key code of a one-hot row pattern on column c.
    function automatic logic [CODE_W-1:0] key_index(input logic [CI_W-1:0] c,
                                                    input logic [NROWS-1:0] v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < NROWS; i++) begin
            r = v[i] ? 32'(i) : r;
        end
        return CODE_W'(32'(c) * 32'(NROWS) + r);
    endfunction

    // Column index after c, wrapping from the last column back to column 0.
    function automatic logic [CI_W-1:0] next_col(input logic [CI_W-1:0] c);
        return (c == CI_W'(NCOLS - 1)) ? {CI_W{1'b0}} : c + CI_W'(1);
    endfunction

    // One-hot column drive for column index c.
    function automatic logic [NCOLS-1:0] col_onehot(input logic [CI_W-1:0] c);
        logic [NCOLS-1:0] v;
        for (int i = 0; i < NCOLS; i++) begin
            v[i] = (CI_W'(i) == c);
        end
        return v;
    endfunction

    logic [NROWS-1:0]  sync1_r;
    logic [NROWS-1:0]  rs_r;
    state_t            state_r;
    state_t            state_s;
    logic [CI_W-1:0]   ci_r;
    logic [CI_W-1:0]   ci_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [NROWS-1:0]  pattern_r;
    logic [NROWS-1:0]  pattern_s;
    logic [NCOLS-1:0]  col_r;
    logic [CODE_W-1:0] key_code_r;
    logic [CODE_W-1:0] code_s;
    logic              key_valid_r;
    logic              valid_s;
    logic              key_held_r;
    logic              held_s;
    logic              overrun_r;
    logic              overrun_s;
    logic              accept_s;

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= {NROWS{1'b0}};
            rs_r    <= {NROWS{1'b0}};
        end else begin
            sync1_r <= row;
            rs_r    <= sync1_r;
        end
    end

    // Next-state, counter and event-port logic.
    always_comb begin
        state_s   = state_r;
        ci_s      = ci_r;
        cnt_s     = cnt_r;
        pattern_s = pattern_r;
        held_s    = key_held_r;
        accept_s  = 1'b0;
        code_s    = key_code_r;
        valid_s   = key_valid_r;
        overrun_s = overrun_r;

        case (state_r)
            ST_SCAN: begin
                // Rows are only trusted on the last dwell cycle, once the
                // column drive has had time to reach the synchroniser output.
                if (cnt_r == CNT_W'(SCAN_DIV - 1)) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (is_onehot(rs_r)) begin
                        state_s   = ST_DEBOUNCE;
                        pattern_s = rs_r;
                    end else begin
                        ci_s = next_col(ci_r);
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (rs_r != pattern_r) begin
                    state_s = ST_SCAN;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_W'(DEB_CYC - 1)) begin
                    state_s  = ST_PRESSED;
                    cnt_s    = {CNT_W{1'b0}};
                    held_s   = 1'b1;
                    accept_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (rs_r == {NROWS{1'b0}}) begin
                    state_s = ST_RELEASE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_PRESSED;
                end
            end
            ST_RELEASE: begin
                if (rs_r != {NROWS{1'b0}}) begin
                    // Release bounce: key counts as still held, no new event.
                    state_s = ST_PRESSED;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_W'(DEB_CYC - 1)) begin
                    state_s = ST_SCAN;
                    cnt_s   = {CNT_W{1'b0}};
                    held_s  = 1'b0;
                    ci_s    = next_col(ci_r);
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_SCAN;
                cnt_s   = {CNT_W{1'b0}};
                held_s  = 1'b0;
            end
        endcase

        // A new event may load in the same cycle the old one is consumed;
        // otherwise it is dropped and flagged, keeping the pending code intact.
        if (accept_s) begin
            if (!key_valid_r || key_ready) begin
                code_s  = key_index(ci_r, pattern_r);
                valid_s = 1'b1;
            end else begin
                overrun_s = 1'b1;
            end
        end else if (key_valid_r && key_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = key_valid_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_SCAN;
            ci_r        <= {CI_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            pattern_r   <= {NROWS{1'b0}};
            col_r       <= col_onehot({CI_W{1'b0}});
            key_code_r  <= {CODE_W{1'b0}};
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            ci_r        <= ci_s;
            cnt_r       <= cnt_s;
            pattern_r   <= pattern_s;
            col_r       <= col_onehot(ci_s);
            key_code_r  <= code_s;
            key_valid_r <= valid_s;
            key_held_r  <= held_s;
            overrun_r   <= overrun_s;
        end
    end

    assign col       = col_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;
    assign overrun   = overrun_r;

endmodule
